uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- 8N1 UART receiver for the SoC serial-input line (the `uart_rx` net at the SoC boundary).
- Synchronises the asynchronous serial input and samples each bit at its midpoint.
- Deserialises received bytes into a small FIFO and presents them to the SoC peripheral bus side through a valid/ready interface.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4 or more.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk_in  input  1  system clock.
- arst  input  1  reset, asynchronous, active-high.
- uart_rx  input  1  serial input; idles high; asynchronous to clk_in.
- rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pop; a pop occurs in any cycle where rx_valid and rx_ready are both 1.
- rx_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: received byte dropped because the FIFO was full.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when the optional feature is absent.

Behaviour:
- Clock and reset: one clock domain, clk_in. arst is asynchronous and active-high.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; bit counter = 0; cycle counter = 0.
  - FIFO pointers = 0, so rx_valid=0 and rx_level=0.
  - frame_err, overrun_err, parity_err = 0.
  - rx_data = 0.
- Reset asserted mid-frame aborts the frame immediately; the FIFO contents are lost.
- Input synchronisation: uart_rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- State machine, cyc = cycle counter:
  - IDLE: when rx_s=0, go to START with cyc=0.
  - START: when cyc = CLK_PER_BIT/2-1 (integer division):
    - rx_s=0: go to DATA with cyc=0, bit=0.
    - rx_s=1: glitch; return to IDLE with no error.
  - DATA: when cyc = CLK_PER_BIT-1, shift rx_s into the shift register LSB first and reset cyc. After bit 7, go to STOP (or PARITY when the feature is enabled).
  - STOP: when cyc = CLK_PER_BIT-1, sample rx_s:
    - rx_s=1: push the byte and return to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rx_s=1, then return to IDLE. Holding the line low (break) yields exactly one frame_err.
- Latency: a pushed byte shows rx_valid=1 in the cycle after the stop-sample cycle. The end-to-end latency from the start-bit falling edge is (2 sync cycles) + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles.
- FIFO:
  - Synchronous; read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished by the extra MSB.
  - rx_data is the combinational read of the head entry.
  - rx_level = wr_ptr - rd_ptr, computed modulo the pointer width.
- FIFO boundary conditions:
  - Push when full with no pop in the same cycle: the byte is dropped, overrun_err pulses, and the FIFO is unchanged.
  - Push and pop in the same cycle when full: both are accepted and rx_level stays FIFO_DEPTH; no overrun.
  - Push and pop in the same cycle when 1 entry is held: level stays 1 and the head advances to the new byte.
  - Pop when empty: ignored, because rx_valid=0.
- Error pulses are registered: each is high for exactly 1 cycle, in the cycle after the detecting sample.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one extra bit at CLK_PER_BIT-1.
  - Parity is even: the XOR of the 8 data bits and the parity bit must equal 0.
  - On mismatch: pulse parity_err, discard the byte, and still go through STOP. A frame that also has a bad stop bit pulses frame_err as well, in a later cycle.
  - The frame becomes 8E1; latency grows by CLK_PER_BIT.
- Undefined: there is no PARITY state, and parity_err is tied to 0.

Decomposition:
- Package uart_rx_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP, BREAK}; PARITY is kept in the enum even when the macro is undefined.
  - Constant UART_DATA_BITS=8.
  - Constant SYNC_STAGES=2.
- Sub-module uart_rx_fifo (parameter FIFO_DEPTH, width 8):
  - Push/pop interface with full, empty and level.
  - Accept-on-full-with-pop is implemented in this sub-module.
  - The top level owns the synchroniser, FSM, counters and error pulses.

Test Plan (CLK_PER_BIT=8, FIFO_DEPTH=4):
1. Send 0xA5 as 8N1 -> rx_valid rises 1+4+72+2 cycles after the falling edge; rx_data=0xA5; no error pulses. Pulse rx_ready -> rx_valid=0, rx_level=0.
2. Low glitch of 3 cycles on an idle line -> FSM returns to IDLE; no push and no errors.
3. Send 0x3C with the stop bit forced low, line held low for 40 cycles -> exactly one frame_err pulse; rx_level stays 0. Then send 0x11 -> 0x11 is received correctly.
4. Send 5 bytes 0x01..0x05 with rx_ready=0 -> rx_level=4; one overrun_err on the 5th byte. Drain -> 0x01, 0x02, 0x03, 0x04 in order.
5. FIFO full and rx_ready=1 held while a 5th byte completes -> the byte is accepted, no overrun, level stays 4; the final byte read is the new one.
6. Assert arst mid-DATA with 2 bytes queued -> rx_valid=0 and rx_level=0 in the same cycle. Release arst, send 0x7E -> received correctly. With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulses and no push.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared state encoding and constants for the UART receiver.
//               PARITY is always part of the encoding; it is only reached
//               when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int SYNC_STAGES    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small synchronous receive FIFO with one extra pointer bit to
//               tell full from empty. A push while full is accepted only
//               when a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_head_data,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(FIFO_DEPTH):0]  o_level
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);

    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic              w_pop;
    logic              w_wr_en;

    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                         (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_pop       = i_pop & ~o_empty;
    // A simultaneous pop makes room, so full only blocks a lone push
    assign w_wr_en     = i_push & (~o_full | w_pop);
    assign o_level     = r_wr_ptr - r_rd_ptr;
    assign o_head_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    // Pointer update for accepted pushes and pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; cleared on reset so the head reads 0 while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver: two-flop input synchroniser, mid-bit
//               sampling FSM, receive FIFO with valid/ready read side and
//               single-cycle framing/overrun (and optional parity) pulses.
//               Define UART_RX_PARITY_EN for 8E1 frames with parity check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk_in,
    input  logic                         arst,
    input  logic                         uart_rx,
    output logic [7:0]                   rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  rx_level,
    output logic                         frame_err,
    output logic                         overrun_err,
    output logic                         parity_err
);

    localparam int c_cyc_w = $clog2(CLK_PER_BIT);
    localparam int c_bit_w = $clog2(UART_DATA_BITS);
    localparam logic [c_cyc_w-1:0] c_half_last = c_cyc_w'(CLK_PER_BIT/2 - 1);
    localparam logic [c_cyc_w-1:0] c_bit_last  = c_cyc_w'(CLK_PER_BIT - 1);
    localparam logic [c_cyc_w-1:0] c_cyc_one   = c_cyc_w'(1);
    localparam logic [c_bit_w-1:0] c_last_bit  = c_bit_w'(UART_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]    r_sync;
    logic                      w_rx_s;
    rx_state_t                 r_state, w_state_nxt;
    logic [c_cyc_w-1:0]        r_cyc, w_cyc_nxt;
    logic [c_bit_w-1:0]        r_bit, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                      w_push;
    logic                      w_frame_det;
    logic                      w_overrun_det;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      r_frame_err;
    logic                      r_overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad, w_par_bad_nxt;
    logic                      w_parity_det;
    logic                      r_parity_err;
`endif

    // Bring the asynchronous line into clk_in; idle level is high
    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // FSM state, bit-timing counter, bit index and shift register
    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Remembers a parity failure so the byte is dropped at the stop bit
    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) r_par_bad <= 1'b0;
        else      r_par_bad <= w_par_bad_nxt;
    end
`endif

    // Next-state logic: start-bit qualify at half bit, then full-bit sampling
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc + c_cyc_one;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_det = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_parity_det  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cyc_nxt = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_nxt = 1'b0;
`endif
                if (!w_rx_s) w_state_nxt = START;
            end
            START: begin
                if (r_cyc == c_half_last) begin
                    w_cyc_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        // Line went back high before mid start bit: glitch
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_cyc == c_bit_last) begin
                    w_cyc_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit == c_last_bit) begin
                        w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cyc == c_bit_last) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = STOP;
                    // Even parity: data bits plus parity bit must XOR to 0
                    if (^{r_shift, w_rx_s}) begin
                        w_parity_det  = 1'b1;
                        w_par_bad_nxt = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (r_cyc == c_bit_last) begin
                    w_cyc_nxt = '0;
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_det = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so a break gives one error only
                w_cyc_nxt = '0;
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: begin
                w_cyc_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (UART_DATA_BITS)
    ) u_fifo (
        .clk         (clk_in),
        .rst         (arst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (rx_ready),
        .o_head_data (rx_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (rx_level)
    );

    assign rx_valid = ~w_fifo_empty;

    // A byte is lost only when full and no pop frees a slot this cycle
    assign w_overrun_det = w_push & w_fifo_full & ~(rx_valid & rx_ready);

    // Error detections registered into one-cycle pulses
    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_frame_det;
            r_overrun_err <= w_overrun_det;
        end
    end

    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

`ifdef UART_RX_PARITY_EN
    // Parity mismatch pulse, aligned like the other error pulses
    always_ff @(posedge clk_in or posedge arst) begin
        if (arst) r_parity_err <= 1'b0;
        else      r_parity_err <= w_parity_det;
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
